reduce_hybrid_ctrl: RTL and testbench
=====================================

Name: reduce_hybrid_ctrl

Overview:
- Frame-level sequencer for the two-lane hybrid sum reduction.
- Each cycle it accepts one pair of WIDTH-bit operands, reduces the pair in parallel (I_0 + I_1), and folds the result into a sequential accumulator.
- The frame is LEN pairs long; LEN is programmed per frame at START.
- Replaces the free-running counter/valid scheme with an explicit START / valid-ready / result-handshake protocol, so the block can sit between a streaming source and a consumer that applies backpressure.

Parameters:
- WIDTH, 16: operand, accumulator and result width.
- CNT_W, 8: width of LEN and of the beat counter; maximum frame is 2^CNT_W-1 pairs.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESETN  in  1  asynchronous active-low reset.
- START  in  1  frame start request; sampled only in IDLE.
- LEN  in  CNT_W  pairs in the frame; latched when START is accepted.
- I_0  in  WIDTH  lane-0 operand.
- I_1  in  WIDTH  lane-1 operand.
- IN_VALID  in  1  I_0/I_1 hold a valid pair.
- IN_READY  out  1  controller accepts a pair this cycle.
- O  out  WIDTH  reduction result.
- V  out  1  O is valid.
- O_READY  in  1  consumer takes O.
- BUSY  out  1  a frame is in progress or its result is pending.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - state=IDLE; acc=0; remaining=0; O=0.
  - IN_READY=0, V=0, BUSY=0.
  - Reset asserted mid-frame aborts the frame; no V is produced for it.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - IN_READY=0, V=0, BUSY=0.
  - START=1 with LEN!=0: go to ACCUM; remaining<=LEN; acc<=0.
  - START=1 with LEN==0: go to DONE; O<=0 (empty-frame sum).
- ACCUM:
  - IN_READY=1 (combinational from state only), BUSY=1.
  - A beat is accepted when IN_VALID and IN_READY are both 1.
  - On each accepted beat: acc<=acc+I_0+I_1, truncated mod 2^WIDTH, no saturation; remaining<=remaining-1.
  - Beat accepted with remaining==1: O<=acc+I_0+I_1; go to DONE; acc<=0.
  - No accepted beat: all state holds. Bubbles are allowed and have no effect on the result.
- DONE:
  - V=1, IN_READY=0, BUSY=1; O is stable while V=1.
  - O_READY=1: go to IDLE; V falls on the next cycle.
  - START is ignored in ACCUM and DONE. A new START is accepted only on or after the first cycle back in IDLE.
- Latency: V rises the cycle after the last beat is accepted. Best-case throughput is LEN+2 cycles per frame (START cycle, LEN beats, DONE cycle with O_READY=1).
- O keeps its last value in IDLE. Only the V qualification matters.
- Arithmetic: the three-operand sum is computed in WIDTH bits. The intermediate I_0+I_1 also wraps.
- Input signals are assumed synchronous to CLK; no CDC logic is included.

Decomposition:
- Shared package: WIDTH and CNT_W defaults, and the state encoding constants (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
- One natural sub-module: pair_accum. It contains the parallel lane adder plus the accumulator register, with inputs clr, en, I_0, I_1 and output sum_next, and uses the same asynchronous active-low reset.
- The FSM, beat counter and output register stay in reduce_hybrid_ctrl.

Test Plan:
- Basic frame: START with LEN=3; pairs (1,2),(3,4),(5,6), one per cycle, IN_VALID held high -> V=1 one cycle after the third beat, O=21; O_READY=1 returns to IDLE and BUSY=0 next cycle.
- Bubbles: LEN=4; pairs (10,10) with IN_VALID=0 gaps of 0–3 random cycles between beats -> O=80; IN_READY stays 1 throughout ACCUM.
- Backpressure and wrap: LEN=2; pairs (0xFFFF,0x0001),(0x8000,0x8001); O_READY held 0 for 5 cycles -> O=0x0001, stable with V=1 all 5 cycles; IN_READY=0 and START is ignored during the hold.
- Empty frame: START with LEN=0 -> DONE on the next cycle with V=1, O=0, and no beats consumed.
- Reset mid-frame: LEN=5; drive RESETN low after 2 beats -> immediately IN_READY=0, BUSY=0, V=0, O=0. After release, a new frame of LEN=1 with pair (7,8) gives O=15, with no carry-over from the aborted frame.
- Back-to-back frames: O_READY tied to 1; START pulses each time BUSY falls, LEN=1, pairs (1,1) then (2,2) -> two single-cycle V pulses with O=2 then O=4.

Source files
------------

// File: rtl/reduce_hybrid_ctrl_pkg.sv
// Shared definitions for the two-lane hybrid sum reduction controller:
// default widths and the frame sequencer state encoding.
package reduce_hybrid_ctrl_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/reduce_hybrid_ctrl_if.sv
// Bus bundle between a streaming source / result consumer and the
// reduction controller.
//
// Handshake rules:
//   input beat  : a pair transfers on a rising edge where IN_VALID and
//                 IN_READY are both 1; IN_READY depends on controller
//                 state only, never on IN_VALID.
//   result      : O transfers on a rising edge where V and O_READY are
//                 both 1; O stays stable while V is 1 and not yet taken.
//   frame start : START/LEN are sampled only while BUSY is 0.
interface reduce_hybrid_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) ();

   logic             START;
   logic [CNT_W-1:0] LEN;
   logic [WIDTH-1:0] I_0;
   logic [WIDTH-1:0] I_1;
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] O;
   logic             V;
   logic             O_READY;
   logic             BUSY;

   // Source/consumer side
   modport master (
      output START, LEN, I_0, I_1, IN_VALID, O_READY,
      input  IN_READY, O, V, BUSY
   );

   // Controller side
   modport slave (
      input  START, LEN, I_0, I_1, IN_VALID, O_READY,
      output IN_READY, O, V, BUSY
   );

endinterface

// File: rtl/reduce_hybrid_ctrl_pair_accum.sv
// Parallel lane adder feeding a sequential accumulator. sum_next is the
// value the accumulator would take on an enabled beat; all arithmetic
// wraps at WIDTH bits, including the intermediate lane sum.
module pair_accum
   import reduce_hybrid_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] I_0,
   input  logic [WIDTH-1:0] I_1,
   output logic [WIDTH-1:0] sum_next
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] lane_sum;

   // Lane reduction and fold into the running total
   always_comb begin
      lane_sum = I_0 + I_1;
      sum_next = acc_q + lane_sum;
   end

   // Clear wins over enable so the last beat of a frame leaves acc at zero
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum_next;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/reduce_hybrid_ctrl.sv
// Frame-level sequencer for the two-lane hybrid sum reduction. A frame of
// LEN pairs is opened by START, each accepted pair is folded into the
// accumulator, and the final sum is held on O with V until the consumer
// takes it. The current state is exposed on dbg_state.
module reduce_hybrid_ctrl
   import reduce_hybrid_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   reduce_hybrid_ctrl_if.slave  bus,
   output state_t               dbg_state
);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_d;
   logic [WIDTH-1:0] o_q;
   logic [WIDTH-1:0] o_d;
   logic             acc_clr;
   logic             acc_en;
   logic             beat;
   logic [WIDTH-1:0] sum_next;

   pair_accum #(
      .WIDTH (WIDTH)
   ) u_pair_accum (
      .clk      (CLK),
      .rst_n    (RESETN),
      .clr      (acc_clr),
      .en       (acc_en),
      .I_0      (bus.I_0),
      .I_1      (bus.I_1),
      .sum_next (sum_next)
   );

   // Next-state, beat counter and result register update
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      o_d     = o_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      beat    = (state_q == ACCUM) && bus.IN_VALID;
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               if (bus.LEN != '0) begin
                  state_d = ACCUM;
                  rem_d   = bus.LEN;
                  acc_clr = 1'b1;
               end else begin
                  // Empty frame: the sum of nothing is zero
                  state_d = DONE;
                  o_d     = '0;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_en = 1'b1;
               rem_d  = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  o_d     = sum_next;
                  state_d = DONE;
                  acc_clr = 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.O_READY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and result registers; reset aborts any frame in flight
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         rem_q   <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         o_q     <= o_d;
      end
   end

   // Handshake outputs decode straight from the state register
   always_comb begin
      bus.IN_READY = (state_q == ACCUM);
      bus.V        = (state_q == DONE);
      bus.BUSY     = (state_q != IDLE);
      bus.O        = o_q;
      dbg_state    = state_q;
   end

endmodule

// File: tb/tb_reduce_hybrid_ctrl.sv
// Directed bench for reduce_hybrid_ctrl: a table of frames with
// hand-computed sums, followed by reset-abort and back-to-back sequences.
module tb_reduce_hybrid_ctrl;
   import reduce_hybrid_ctrl_pkg::*;

   localparam int W  = 16;
   localparam int CW = 8;

   typedef struct packed {
      logic [CW-1:0]     len;
      logic [3:0][W-1:0] a;
      logic [3:0][W-1:0] b;
      logic [7:0]        max_gap;
      logic [7:0]        hold;
      logic [W-1:0]      exp_o;
   } vec_t;

   logic   CLK;
   logic   RESETN;
   state_t dbg_state;

   reduce_hybrid_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   reduce_hybrid_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   vec_t vecs[6];

   // Clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [CW-1:0] len,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic [W-1:0] a2, input logic [W-1:0] b2,
                               input logic [W-1:0] a3, input logic [W-1:0] b3,
                               input logic [7:0] max_gap, input logic [7:0] hold,
                               input logic [W-1:0] exp_o);
      vec_t v;
      v.len     = len;
      v.a[0]    = a0; v.b[0] = b0;
      v.a[1]    = a1; v.b[1] = b1;
      v.a[2]    = a2; v.b[2] = b2;
      v.a[3]    = a3; v.b[3] = b3;
      v.max_gap = max_gap;
      v.hold    = hold;
      v.exp_o   = exp_o;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.START    = 1'b0;
      bus.LEN      = '0;
      bus.I_0      = '0;
      bus.I_1      = '0;
      bus.IN_VALID = 1'b0;
      bus.O_READY  = 1'b0;
   endtask

   // One pair, optionally preceded by bubble cycles; runs from a negedge in ACCUM
   task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         bus.IN_VALID = 1'b0;
         bus.I_0      = $urandom_range(0, 16'hFFFF);
         bus.I_1      = $urandom_range(0, 16'hFFFF);
         check("in_ready_bubble", bus.IN_READY, 1);
         check("v_low_in_accum", bus.V, 0);
         @(negedge CLK);
      end
      bus.IN_VALID = 1'b1;
      bus.I_0      = a;
      bus.I_1      = b;
      check("in_ready_beat", bus.IN_READY, 1);
      check("busy_in_accum", bus.BUSY, 1);
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
   endtask

   // Full frame: START, beats, result hold, hand-off; starts and ends at a negedge in IDLE
   task automatic run_frame(input vec_t v);
      logic [W-1:0] exp;
      check("idle_busy", bus.BUSY, 0);
      check("idle_in_ready", bus.IN_READY, 0);
      check("idle_v", bus.V, 0);
      exp_q.push_back(v.exp_o);
      bus.START = 1'b1;
      bus.LEN   = v.len;
      @(negedge CLK);
      bus.START = 1'b0;
      for (int i = 0; i < int'(v.len); i++) begin
         drive_beat(v.a[i], v.b[i], (v.max_gap == 0) ? 0 : $urandom_range(0, int'(v.max_gap)));
      end
      // V is up the cycle after the last beat (or right after START for LEN=0)
      check("v_after_last_beat", bus.V, 1);
      check("in_ready_done", bus.IN_READY, 0);
      check("state_done", dbg_state, DONE);
      for (int h = 0; h < int'(v.hold); h++) begin
         bus.START    = 1'b1;
         bus.LEN      = 8'd9;
         bus.IN_VALID = 1'b1;
         bus.O_READY  = 1'b0;
         check("hold_v", bus.V, 1);
         check("hold_o", bus.O, v.exp_o);
         check("hold_in_ready", bus.IN_READY, 0);
         check("hold_busy", bus.BUSY, 1);
         @(negedge CLK);
      end
      bus.START    = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.O_READY  = 1'b1;
      exp = exp_q.pop_front();
      check("result_o", bus.O, exp);
      check("result_v", bus.V, 1);
      @(negedge CLK);
      bus.O_READY = 1'b0;
      check("post_v", bus.V, 0);
      check("post_busy", bus.BUSY, 0);
      check("post_o_kept", bus.O, v.exp_o);
   endtask

   initial begin
      vecs[0] = mk(8'd3, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0, 8'd0, 8'd0, 16'd21);
      vecs[1] = mk(8'd4, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 8'd3, 8'd0, 16'd80);
      vecs[2] = mk(8'd2, 16'hFFFF, 16'h0001, 16'h8000, 16'h8001, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd5, 16'h0001);
      vecs[3] = mk(8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd2, 16'd0);
      vecs[4] = mk(8'd4, 16'h1234, 16'h1111, 16'hF000, 16'h2000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 8'd1, 8'd1, 16'h3343);
      vecs[5] = mk(8'd1, 16'd7, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 16'd15);

      // Reset
      idle_inputs();
      RESETN = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_in_ready", bus.IN_READY, 0);
      check("rst_v", bus.V, 0);
      check("rst_busy", bus.BUSY, 0);
      check("rst_o", bus.O, 0);
      check("rst_state", dbg_state, IDLE);
      RESETN = 1'b1;
      @(negedge CLK);

      // Table-driven frames
      for (int k = 0; k < 5; k++) begin
         run_frame(vecs[k]);
         @(negedge CLK);
      end

      // Reset mid-frame: two beats of a LEN=5 frame, then abort
      bus.START = 1'b1;
      bus.LEN   = 8'd5;
      @(negedge CLK);
      bus.START = 1'b0;
      drive_beat(16'd100, 16'd200, 0);
      drive_beat(16'd300, 16'd400, 0);
      bus.IN_VALID = 1'b1;
      #1 RESETN = 1'b0;
      #1;
      check("abort_in_ready", bus.IN_READY, 0);
      check("abort_busy", bus.BUSY, 0);
      check("abort_v", bus.V, 0);
      check("abort_o", bus.O, 0);
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      RESETN = 1'b1;
      @(negedge CLK);
      check("abort_no_v", bus.V, 0);
      run_frame(vecs[5]);

      // Back-to-back single-pair frames with O_READY tied high
      bus.O_READY = 1'b1;
      for (int f = 1; f <= 2; f++) begin
         int waited;
         waited = 0;
         while (bus.BUSY && waited < 10) begin
            @(negedge CLK);
            waited++;
         end
         check("b2b_busy_fell", bus.BUSY, 0);
         bus.START = 1'b1;
         bus.LEN   = 8'd1;
         @(negedge CLK);
         bus.START    = 1'b0;
         bus.IN_VALID = 1'b1;
         bus.I_0      = W'(f);
         bus.I_1      = W'(f);
         @(negedge CLK);
         bus.IN_VALID = 1'b0;
         check("b2b_v", bus.V, 1);
         check("b2b_o", bus.O, 2 * f);
         @(negedge CLK);
         check("b2b_v_single", bus.V, 0);
      end
      bus.O_READY = 1'b0;

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
